flp_to_fx_sink: RTL and testbench

FLP_TO_FX_SINK -- requirements
Module: flp_to_fx_sink

---
 rtl/flp_to_fx_sink_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/flp_to_fx_sink.sv | 188 ++++++++++++++++++
 tb/tb_flp_to_fx_sink.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/flp_to_fx_sink_pkg.sv
// Shared float-format utilities: default field widths, exponent bias and operand classes.
package flp_to_fx_sink_pkg;

    localparam int FLT_N_EXP  = 8;
    localparam int FLT_N_MANT = 23;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } flt_class_e;

    function automatic int flt_bias(input int n_exp);
        return (1 << (n_exp - 1)) - 1;
    endfunction

    // Beyond this many positions any shift either clears or saturates the result.
    function automatic int flt_shift_limit(input int n_mant, input int n_frac);
        return n_mant + n_frac + 2;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/flp_to_fx_sink.sv
// Float-to-fixed sink: 3-stage convert pipeline feeding an output FIFO.
// Define FLP_SINK_STATS_EN to add the 16-bit saturating sat_cnt output.
module flp_to_fx_sink
    import flp_to_fx_sink_pkg::*;
#(
    parameter int n_exp  = FLT_N_EXP,
    parameter int n_mant = FLT_N_MANT,
    parameter int n_int  = 1,
    parameter int n_frac = 14,
    parameter int Depth  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [n_exp+n_mant:0]         in,
    input  logic                          valid,
    output logic [n_int+n_frac:0]         out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          sat,
    output logic                          ovf
`ifdef FLP_SINK_STATS_EN
    ,
    output logic [15:0]                   sat_cnt
`endif
);

    localparam int W       = 1 + n_int + n_frac;
    localparam int BIAS    = flt_bias(n_exp);
    localparam int LMAX    = flt_shift_limit(n_mant, n_frac);
    localparam int SA_W    = $clog2(LMAX + 2);
    localparam int MAG_W   = W + 1;
    localparam int EXT_RAW = n_mant + LMAX + 2;
    localparam int EXT     = (EXT_RAW > MAG_W) ? EXT_RAW : MAG_W + 1;

    localparam logic [SA_W-1:0]  LMAX_A  = SA_W'(LMAX);
    localparam logic [MAG_W-1:0] LIM_POS = {2'b00, {(W-1){1'b1}}};
    localparam logic [MAG_W-1:0] LIM_NEG = {2'b01, {(W-1){1'b0}}};

    // ---------------- S1: unpack, classify, shift amount ----------------
    logic              f_sign;
    logic [n_exp-1:0]  f_exp;
    logic [n_mant-1:0] f_mant;
    flt_class_e        cls_c;
    logic              left_c;
    logic [SA_W-1:0]   amt_c;
    int                sh_c;
    int                abs_c;

    assign {f_sign, f_exp, f_mant} = in;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        cls_c = NORM;
        if (f_exp == '0) begin
            cls_c = ZERO;
        end else if (&f_exp) begin
            if (f_mant == '0) cls_c = INF;
            else              cls_c = NAN;
        end
        // Fixed value = {1,mant} * 2^(exp - bias - n_mant + n_frac)
        sh_c   = int'(f_exp) - BIAS - n_mant + n_frac;
        left_c = (sh_c >= 0);
        abs_c  = left_c ? sh_c : -sh_c;
        if (abs_c > LMAX + 1) abs_c = LMAX + 1;
        amt_c  = SA_W'(abs_c);
    end

    logic              s1_valid;
    logic              s1_sign;
    flt_class_e        s1_cls;
    logic [n_mant-1:0] s1_mant;
    logic              s1_left;
    logic [SA_W-1:0]   s1_amt;

    // ---------------- S2: shift and round magnitude ----------------
    logic [n_mant:0]    sig;
    logic [EXT-1:0]     rsh_c;
    logic [EXT-1:0]     val_c;
    logic               big_c;
    logic [MAG_W-1:0]   mag_c;

    assign sig = {1'b1, s1_mant};

    always_comb begin
        rsh_c = '0;
        val_c = '0;
        big_c = 1'b0;
        case (s1_cls)
            INF: big_c = 1'b1;
            NORM: begin
                if (s1_left) begin
                    if (s1_amt > LMAX_A) big_c = 1'b1;
                    else                 val_c = EXT'(sig) << s1_amt;
                end else if (s1_amt <= LMAX_A) begin
                    // The extra LSB catches the half bit; adding it rounds ties away from zero.
                    rsh_c = (EXT'(sig) << 1) >> s1_amt;
                    val_c = (rsh_c >> 1) + EXT'(rsh_c[0]);
                end
            end
            default: val_c = '0;
        endcase
        if (|val_c[EXT-1:MAG_W]) big_c = 1'b1;
        mag_c = val_c[MAG_W-1:0];
    end

    logic             s2_valid;
    logic             s2_sign;
    logic             s2_big;
    logic [MAG_W-1:0] s2_mag;

    // ---------------- S3: sign and saturate ----------------
    logic         sat_c;
    logic [W-1:0] res_c;

    always_comb begin
        sat_c = s2_big || (s2_sign ? (s2_mag > LIM_NEG) : (s2_mag > LIM_POS));
        if (sat_c)        res_c = s2_sign ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else if (s2_sign) res_c = -s2_mag[W-1:0];
        else              res_c = s2_mag[W-1:0];
    end

    logic         s3_valid;
    logic [W-1:0] s3_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            s1_valid <= valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
        end
    end

    // Payload registers follow their valid bit and need no reset.
    always_ff @(posedge clk) begin
        s1_sign <= f_sign;
        s1_cls  <= cls_c;
        s1_mant <= f_mant;
        s1_left <= left_c;
        s1_amt  <= amt_c;
        s2_sign <= s1_sign;
        s2_big  <= big_c;
        s2_mag  <= mag_c;
        s3_data <= res_c;
    end

    // ---------------- output FIFO and sticky flags ----------------
    logic full;
    logic empty;

    sync_fifo #(
        .WIDTH (W),
        .DEPTH (Depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s3_valid),
        .pop   (out_ready),
        .wdata (s3_data),
        .rdata (out),
        .full  (full),
        .empty (empty)
    );

    assign out_valid = !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            sat <= 1'b0;
            ovf <= 1'b0;
        end else begin
            if (s2_valid && sat_c) sat <= 1'b1;
            // A full FIFO is never empty, so out_ready alone tells whether a pop frees a slot.
            if (s3_valid && full && !out_ready) ovf <= 1'b1;
        end
    end

`ifdef FLP_SINK_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)                                          sat_cnt <= '0;
        else if (s2_valid && sat_c && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_flp_to_fx_sink.sv
// Scoreboard bench for flp_to_fx_sink with float32 input and Q1.14 output.
module tb_flp_to_fx_sink;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_f = '0;
    logic        valid = 1'b0;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        sat;
    logic        ovf;
`ifdef FLP_SINK_STATS_EN
    logic [15:0] sat_cnt;
`endif

    flp_to_fx_sink #(
        .n_exp  (8),
        .n_mant (23),
        .n_int  (1),
        .n_frac (14),
        .Depth  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in_f),
        .valid     (valid),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat       (sat),
        .ovf       (ovf)
`ifdef FLP_SINK_STATS_EN
        ,
        .sat_cnt   (sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Monitor: a handshake seen at the falling edge completes on the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: got 0x%0h with no expected word queued", out);
                end else begin
                    check("out_word", out, exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [31:0] f, input logic [15:0] e, input bit keep);
        in_f  = f;
        valid = 1'b1;
        if (keep) exp_q.push_back(e);
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst   = 1'b1;
        valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_left_in_queue"}, exp_q.size(), 0);
        check({tag, "_out_valid_after"}, out_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] f;
        int          seen;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out", out, 16'h0000);
        check("rst_sat", sat, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        rst = 1'b0;

        // Basic values and three-cycle latency
        send(32'h3F800000, 16'h4000, 1'b1);
        send(32'h3F000000, 16'h2000, 1'b1);
        send(32'hBE800000, 16'hF000, 1'b1);
        check("latency_not_yet", out_valid, 1'b0);
        @(posedge clk);
        #1;
        check("latency_valid", out_valid, 1'b1);
        check("latency_head", out, 16'h4000);
        drain("basic");

        // Rounding ties away from zero and underflow to zero
        send(32'h38C00000, 16'h0002, 1'b1);
        send(32'hB8C00000, 16'hFFFE, 1'b1);
        send(32'h00800000, 16'h0000, 1'b1);
        drain("round");
        check("round_sat", sat, 1'b0);

        // NaN, subnormal, and the most negative value that still fits
        send(32'h7FC00000, 16'h0000, 1'b1);
        send(32'h00000001, 16'h0000, 1'b1);
        send(32'hC0000000, 16'h8000, 1'b1);
        drain("special");
        check("special_sat", sat, 1'b0);
        check("special_ovf", ovf, 1'b0);

        // Saturation: overrange, -inf, round-up overflow, huge exponent, +inf
        send(32'h40400000, 16'h7FFF, 1'b1);
        send(32'hFF800000, 16'h8000, 1'b1);
        send(32'h3FFFFFFF, 16'h7FFF, 1'b1);
        send(32'h7F7FFFFF, 16'h7FFF, 1'b1);
        send(32'h7F800000, 16'h7FFF, 1'b1);
        drain("saturate");
        check("saturate_sat", sat, 1'b1);
        check("saturate_ovf", ovf, 1'b0);

        pulse_reset();
        check("reset_clears_sat", sat, 1'b0);

        // FIFO overflow with a stalled consumer
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            f = 32'h3F800000 - (32'(i) << 23);
            send(f, 16'h4000 >> i, i < 8);
        end
        @(posedge clk);
        #1;
        check("full_no_ovf_yet", ovf, 1'b0);
        check("full_head", out, 16'h4000);
        @(posedge clk);
        #1;
        check("ovf_after_9th", ovf, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("hold_valid", out_valid, 1'b1);
        check("hold_head", out, 16'h4000);
        out_ready = 1'b1;
        drain("overflow");

        pulse_reset();

        // Push and pop together while full: nothing dropped
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 11) out_ready = 1'b1;
            f = 32'h3F800000 - (32'(i) << 23);
            send(f, 16'h4000 >> i, 1'b1);
        end
        drain("full_pushpop");
        check("full_pushpop_ovf", ovf, 1'b0);

        // Reset with samples in flight
        send(32'h40400000, 16'h0000, 1'b0);
        send(32'hFF800000, 16'h0000, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        check("flush_no_output", seen, 0);
        check("flush_sat", sat, 1'b0);
        check("flush_ovf", ovf, 1'b0);

        // Input accepted right after reset release
        pulse_reset();
        send(32'h3F800000, 16'h4000, 1'b1);
        drain("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
